// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised inter-stage pipeline register with
// per-slice valid, stall, flush, bubble and occupancy/bubble counters.
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter bit ZERO_ON_BUBBLE = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       bubble,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            v_n;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_n;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_n;
  logic [CNT_W-1:0]            bc_q;
  logic                        s0_v;

  assign s0_v = in_valid & ~bubble;

  always_comb begin
    v_n = v_q;
    d_n = d_q;
    if (flush) begin
      v_n = '0;
      if (ZERO_ON_BUBBLE) d_n = '0;
    end else if (!stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        v_n[k] = v_q[k-1];
        d_n[k] = d_q[k-1];
      end
      v_n[0] = s0_v;
      d_n[0] = (ZERO_ON_BUBBLE && !s0_v) ? '0 : in_data;
    end
  end

  // occupancy reflects the post-edge valid bits
  always_comb begin
    occ_n = '0;
    for (int i = 0; i < DEPTH; i++)
      occ_n = occ_n + OCC_W'(v_n[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
      bc_q  <= '0;
    end else begin
      v_q   <= v_n;
      d_q   <= d_n;
      occ_q <= occ_n;
      if (!v_q[DEPTH-1] && (bc_q != {CNT_W{1'b1}}))
        bc_q <= bc_q + CNT_W'(1);
    end
  end

  assign out_valid  = v_q[DEPTH-1];
  assign out_data   = d_q[DEPTH-1];
  assign occupancy  = occ_q;
  assign bubble_cnt = bc_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: three configurations driven by shared stimulus,
// checked per cycle against a FIFO-style reference model.
module tb_pipe_reg_chain;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } ent_t;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [31:0] occ;
    logic [31:0] bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, bubble;
  logic [31:0] in_data;

  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  occ0;
  logic [0:0]  occ1;
  logic [1:0]  occ2;
  logic [3:0]  bc0_o;
  logic [15:0] bc1_o;
  logic [2:0]  bc2_o;

  ent_t m0[$], m1[$], m2[$];
  int   bc0, bc1, bc2;
  exp_t e0[$], e1[$], e2[$];

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .ZERO_ON_BUBBLE(1'b1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .bubble(bubble),
    .out_valid(ov0), .out_data(od0), .occupancy(occ0), .bubble_cnt(bc0_o)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .ZERO_ON_BUBBLE(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .bubble(bubble),
    .out_valid(ov1), .out_data(od1), .occupancy(occ1), .bubble_cnt(bc1_o)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .ZERO_ON_BUBBLE(1'b0), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .bubble(bubble),
    .out_valid(ov2), .out_data(od2), .occupancy(occ2), .bubble_cnt(bc2_o)
  );

  // Chain modelled as a fixed-length FIFO: index 0 is the output slice.
  task automatic model_step(ref ent_t q[$], ref int bc,
                            input int cmax, input bit zob,
                            output exp_t e);
    ent_t n;
    int   occ;
    if (rst) begin
      foreach (q[i]) q[i] = '0;
      bc = 0;
    end else begin
      if (!q[0].v && bc < cmax) bc++;
      if (flush) begin
        foreach (q[i]) begin
          q[i].v = 1'b0;
          if (zob) q[i].d = '0;
        end
      end else if (!stall) begin
        n.v = in_valid && !bubble;
        n.d = (zob && !n.v) ? 32'h0 : in_data;
        void'(q.pop_front());
        q.push_back(n);
      end
    end
    occ = 0;
    foreach (q[i]) occ += int'(q[i].v);
    e.v   = q[0].v;
    e.d   = q[0].d;
    e.occ = 32'(occ);
    e.bc  = 32'(bc);
  endtask

  task automatic drive(input bit r, input bit v, input logic [31:0] d,
                       input bit s, input bit f, input bit b);
    exp_t x;
    rst = r; in_valid = v; in_data = d;
    stall = s; flush = f; bubble = b;
    model_step(m0, bc0, 15, 1'b1, x); e0.push_back(x);
    model_step(m1, bc1, 65535, 1'b0, x); e1.push_back(x);
    model_step(m2, bc2, 7, 1'b0, x); e2.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic no_exp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t: no expectation queued", nm, $time);
  endtask

  // monitor: samples after each active edge and pops the expectation
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (e0.size() == 0) no_exp("u0");
      else begin
        x = e0.pop_front();
        chk("u0.out_valid", 32'(ov0), 32'(x.v));
        chk("u0.out_data", od0, x.d);
        chk("u0.occupancy", 32'(occ0), x.occ);
        chk("u0.bubble_cnt", 32'(bc0_o), x.bc);
      end
      if (e1.size() == 0) no_exp("u1");
      else begin
        x = e1.pop_front();
        chk("u1.out_valid", 32'(ov1), 32'(x.v));
        chk("u1.out_data", od1, x.d);
        chk("u1.occupancy", 32'(occ1), x.occ);
        chk("u1.bubble_cnt", 32'(bc1_o), x.bc);
      end
      if (e2.size() == 0) no_exp("u2");
      else begin
        x = e2.pop_front();
        chk("u2.out_valid", 32'(ov2), 32'(x.v));
        chk("u2.out_data", od2, x.d);
        chk("u2.occupancy", 32'(occ2), x.occ);
        chk("u2.bubble_cnt", 32'(bc2_o), x.bc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) m0.push_back('0);
    m1.push_back('0);
    for (int i = 0; i < 2; i++) m2.push_back('0);
    bc0 = 0; bc1 = 0; bc2 = 0;

    drive(1, 0, 32'h0, 0, 0, 0);
    drive(1, 0, 32'h0, 0, 0, 0);
    drive(0, 1, 32'h11, 0, 0, 0);
    drive(0, 1, 32'h22, 0, 0, 0);
    drive(0, 1, 32'h33, 0, 0, 0);
    drive(0, 1, 32'hFF, 1, 0, 0);
    drive(0, 1, 32'hFF, 1, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    drive(0, 1, 32'h11, 0, 0, 0);
    drive(0, 1, 32'h22, 0, 0, 0);
    drive(0, 1, 32'h33, 0, 0, 0);
    drive(0, 1, 32'hEE, 1, 1, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    drive(0, 1, 32'hAA, 0, 0, 0);
    drive(0, 1, 32'hBB, 0, 0, 1);
    drive(0, 1, 32'hCC, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      drive(0, 0, $urandom, 0, 0, 0);
    drive(0, 1, 32'h01, 0, 0, 0);
    drive(0, 1, 32'h02, 0, 0, 0);
    drive(1, 1, 32'h03, 0, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0);
    drive(1, 1, 32'h5A, 0, 0, 0);
    drive(0, 1, 32'h5A, 0, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(63) == 0,
            $urandom_range(3) != 0,
            $urandom,
            $urandom_range(3) == 0,
            $urandom_range(15) == 0,
            $urandom_range(5) == 0);

    done = 1'b1;
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
